// File: rtl/sr_cmd_pkg.sv
// Shared types and constants for the SR command generator.
package sr_cmd_pkg;

    localparam int CNT_W    = 8;
    localparam bit PRIO_SET = 1'b0;
    localparam bit PRIO_CLR = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

endpackage

// File: rtl/sr_debounce.sv
// One request channel: 2-flop synchroniser, counting debouncer and
// rising-edge detector on the debounced level.
module sr_debounce
    import sr_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_d;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= i_raw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            // Any agreeing cycle restarts the count, so short glitches vanish.
            if (r_sync2 != r_stable) begin
                if (r_cnt == DEB_LAST) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_rise = r_stable & ~r_stable_d;

endmodule

// File: rtl/sr_cmd_gen.sv
// Arbitrates debounced set/clear events into mutually exclusive one-cycle
// S/R pulses, spaced by a lockout window with one pending slot per channel.
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 2,
    parameter bit CLEAR_PRIORITY  = PRIO_CLR
) (
    input  logic clk,
    input  logic reset,
    input  logic set_req,
    input  logic clr_req,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict
);

    localparam logic [CNT_W-1:0] LOCK_INIT = CNT_W'(LOCKOUT_CYCLES);

    logic w_set_ev;
    logic w_clr_ev;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
        .clk    (clk),
        .reset  (reset),
        .i_raw  (set_req),
        .o_rise (w_set_ev)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
        .clk    (clk),
        .reset  (reset),
        .i_raw  (clr_req),
        .o_rise (w_clr_ev)
    );

    state_e           r_state;
    logic [CNT_W-1:0] r_lock_cnt;
    logic             r_set_pend;
    logic             r_clr_pend;
    logic             r_s;
    logic             r_r;
    logic             r_busy;
    logic             r_conflict;

    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_set_pend_nxt;
    logic             w_clr_pend_nxt;
    logic             w_s_nxt;
    logic             w_r_nxt;
    logic             w_busy_nxt;
    logic             w_conflict_nxt;

    logic w_set_any;
    logic w_clr_any;
    logic w_pick_r;
    logic w_last_lock;

    assign w_set_any   = r_set_pend | w_set_ev;
    assign w_clr_any   = r_clr_pend | w_clr_ev;
    assign w_pick_r    = w_clr_any & (~w_set_any | (CLEAR_PRIORITY == PRIO_CLR));
    assign w_last_lock = (r_lock_cnt == CNT_W'(1));

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_lock_cnt;
        w_set_pend_nxt = w_set_any;
        w_clr_pend_nxt = w_clr_any;
        w_s_nxt        = 1'b0;
        w_r_nxt        = 1'b0;
        w_busy_nxt     = r_busy;
        w_conflict_nxt = 1'b0;

        // The last LOCK cycle decides like IDLE so a pending command needs no gap.
        if ((r_state == IDLE) || w_last_lock) begin
            if (w_set_any | w_clr_any) begin
                w_s_nxt        = ~w_pick_r;
                w_r_nxt        = w_pick_r;
                w_conflict_nxt = w_set_any & w_clr_any;
                w_set_pend_nxt = w_pick_r ? w_set_any : 1'b0;
                w_clr_pend_nxt = w_pick_r ? 1'b0 : w_clr_any;
                w_state_nxt    = LOCK;
                w_cnt_nxt      = LOCK_INIT;
                w_busy_nxt     = 1'b1;
            end else begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        end else begin
            w_cnt_nxt = r_lock_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_lock_cnt <= '0;
            r_set_pend <= 1'b0;
            r_clr_pend <= 1'b0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_busy     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_cnt_nxt;
            r_set_pend <= w_set_pend_nxt;
            r_clr_pend <= w_clr_pend_nxt;
            r_s        <= w_s_nxt;
            r_r        <= w_r_nxt;
            r_busy     <= w_busy_nxt;
            r_conflict <= w_conflict_nxt;
        end
    end

    assign S        = r_s;
    assign R        = r_r;
    assign busy     = r_busy;
    assign conflict = r_conflict;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: two instances (default and a long-lockout, set-priority
// variant) share the request lines and are compared against a timeline model.
module tb_sr_cmd_gen;

    localparam int MAXN = 200;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic s1, r1, busy1, conf1;
    logic s2, r2, busy2, conf2;

    int n_checks = 0;
    int n_pass   = 0;

    bit         ws[MAXN];
    bit         wc[MAXN];
    logic [3:0] obs[2][MAXN];
    logic [3:0] exp_v[2][MAXN];
    int         cfg_deb[2]  = '{4, 1};
    int         cfg_lock[2] = '{2, 12};
    int         cfg_prio[2] = '{1, 0};

    always #5 clk = ~clk;

    sr_cmd_gen #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(2), .CLEAR_PRIORITY(1'b1)) u_dut1 (
        .clk(clk), .reset(rst_n), .set_req(set_req), .clr_req(clr_req),
        .S(s1), .R(r1), .busy(busy1), .conflict(conf1)
    );

    sr_cmd_gen #(.DEBOUNCE_CYCLES(1), .LOCKOUT_CYCLES(12), .CLEAR_PRIORITY(1'b0)) u_dut2 (
        .clk(clk), .reset(rst_n), .set_req(set_req), .clr_req(clr_req),
        .S(s2), .R(r2), .busy(busy2), .conflict(conf2)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_waves();
        for (int i = 0; i < MAXN; i++) begin
            ws[i] = 1'b0;
            wc[i] = 1'b0;
        end
    endtask

    task automatic reset_dut();
        rst_n   = 1'b0;
        set_req = 1'b0;
        clr_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Edge e (0 = first edge after release) samples ws[e]/wc[e]; obs[.][e] is cycle e.
    task automatic run_waves(input int n);
        reset_dut();
        for (int e = 0; e < n; e++) begin
            set_req = ws[e];
            clr_req = wc[e];
            @(posedge clk);
            #1;
            obs[0][e] = {s1, r1, busy1, conf1};
            obs[1][e] = {s2, r2, busy2, conf2};
            @(negedge clk);
        end
    endtask

    // Timeline model: a level is accepted once the last DEB synchronised samples
    // all disagree with it; a rise is an event one edge later; commands are
    // scheduled against the next free edge with one pending slot per channel.
    task automatic model(input int d, input int n);
        int deb, lock, nf, idx;
        bit st_s, st_c, ps, pc, rs, rc, pick_r, all_s, all_c, vs, vc;
        bit ev_s[MAXN];
        bit ev_c[MAXN];
        deb  = cfg_deb[d];
        lock = cfg_lock[d];
        for (int e = 0; e < MAXN; e++) begin
            exp_v[d][e] = 4'b0000;
            ev_s[e] = 1'b0;
            ev_c[e] = 1'b0;
        end
        st_s = 1'b0;
        st_c = 1'b0;
        for (int e = 0; e < n; e++) begin
            all_s = 1'b1;
            all_c = 1'b1;
            for (int j = 2; j <= deb + 1; j++) begin
                idx = e - j;
                vs = (idx >= 0) ? ws[idx] : 1'b0;
                vc = (idx >= 0) ? wc[idx] : 1'b0;
                if (vs == st_s) all_s = 1'b0;
                if (vc == st_c) all_c = 1'b0;
            end
            if (all_s) begin
                st_s = !st_s;
                if (st_s && (e + 1 < n)) ev_s[e+1] = 1'b1;
            end
            if (all_c) begin
                st_c = !st_c;
                if (st_c && (e + 1 < n)) ev_c[e+1] = 1'b1;
            end
        end
        nf = 0;
        ps = 1'b0;
        pc = 1'b0;
        for (int e = 0; e < n; e++) begin
            rs = ps | ev_s[e];
            rc = pc | ev_c[e];
            if ((e >= nf) && (rs || rc)) begin
                pick_r = rc && (!rs || (cfg_prio[d] == 1));
                exp_v[d][e][3] = !pick_r;
                exp_v[d][e][2] = pick_r;
                exp_v[d][e][0] = rs && rc;
                for (int b = e; b < e + lock; b++)
                    if (b < n) exp_v[d][b][1] = 1'b1;
                ps = pick_r ? rs : 1'b0;
                pc = pick_r ? 1'b0 : rc;
                nf = e + lock;
            end else begin
                ps = rs;
                pc = rc;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({s1, r1, busy1, conf1} !== 4'b0000)
            $display("FAIL reset_dut1: S,R,busy,conflict=%b expected 0000", {s1, r1, busy1, conf1});
        else n_pass++;
        n_checks++;
        if ({s2, r2, busy2, conf2} !== 4'b0000)
            $display("FAIL reset_dut2: S,R,busy,conflict=%b expected 0000", {s2, r2, busy2, conf2});
        else n_pass++;
        n_checks++;
        if (u_dut1.u_set_db.r_cnt !== 8'd0)
            $display("FAIL reset_cnt: debounce count=%0d expected 0", u_dut1.u_set_db.r_cnt);
        else n_pass++;
    endtask

    task automatic test_single_set();
        clear_waves();
        for (int e = 10; e < 40; e++) ws[e] = 1'b1;
        run_waves(40);
        model(0, 40);
        model(1, 40);
        n_checks++;
        if (obs[0][16] !== 4'b1010)
            $display("FAIL single_set_c16: S,R,busy,conflict=%b expected 1010", obs[0][16]);
        else n_pass++;
        for (int d = 0; d < 2; d++)
            for (int e = 0; e < 40; e++) begin
                n_checks++;
                if (obs[d][e] !== exp_v[d][e])
                    $display("FAIL single_set dut%0d cycle %0d: got %b expected %b", d + 1, e, obs[d][e], exp_v[d][e]);
                else n_pass++;
            end
    endtask

    task automatic test_glitch();
        clear_waves();
        for (int e = 10; e < 13; e++) ws[e] = 1'b1;
        run_waves(30);
        model(0, 30);
        model(1, 30);
        n_checks++;
        if (u_dut1.u_set_db.r_cnt !== 8'd0)
            $display("FAIL glitch_cnt: debounce count=%0d expected 0", u_dut1.u_set_db.r_cnt);
        else n_pass++;
        for (int d = 0; d < 2; d++)
            for (int e = 0; e < 30; e++) begin
                n_checks++;
                if (obs[d][e] !== exp_v[d][e])
                    $display("FAIL glitch dut%0d cycle %0d: got %b expected %b", d + 1, e, obs[d][e], exp_v[d][e]);
                else n_pass++;
            end
    endtask

    task automatic test_simultaneous();
        clear_waves();
        for (int e = 10; e < 45; e++) begin
            ws[e] = 1'b1;
            wc[e] = 1'b1;
        end
        run_waves(45);
        model(0, 45);
        model(1, 45);
        n_checks++;
        if (obs[0][16] !== 4'b0111)
            $display("FAIL simul_r_conflict: got %b expected 0111", obs[0][16]);
        else n_pass++;
        n_checks++;
        if (obs[0][18] !== 4'b1010)
            $display("FAIL simul_s_after: got %b expected 1010", obs[0][18]);
        else n_pass++;
        for (int d = 0; d < 2; d++)
            for (int e = 0; e < 45; e++) begin
                n_checks++;
                if (obs[d][e] !== exp_v[d][e] || (obs[d][e][3] & obs[d][e][2]) !== 1'b0)
                    $display("FAIL simul dut%0d cycle %0d: got %b expected %b", d + 1, e, obs[d][e], exp_v[d][e]);
                else n_pass++;
            end
    endtask

    task automatic test_lock_pending();
        int r_cnt2;
        clear_waves();
        for (int e = 10; e < 40; e++) ws[e] = 1'b1;
        for (int e = 11; e < 17; e++) wc[e] = 1'b1;
        for (int e = 19; e < 40; e++) wc[e] = 1'b1;
        run_waves(40);
        model(0, 40);
        model(1, 40);
        n_checks++;
        if (obs[0][18] !== 4'b0110)
            $display("FAIL pend_r_dut1: got %b expected 0110", obs[0][18]);
        else n_pass++;
        n_checks++;
        if (obs[1][25] !== 4'b0110)
            $display("FAIL pend_r_dut2: got %b expected 0110", obs[1][25]);
        else n_pass++;
        r_cnt2 = 0;
        for (int e = 0; e < 40; e++) if (obs[1][e][2] === 1'b1) r_cnt2++;
        n_checks++;
        if (r_cnt2 != 1)
            $display("FAIL pend_merge: R pulses=%0d expected 1", r_cnt2);
        else n_pass++;
        for (int d = 0; d < 2; d++)
            for (int e = 0; e < 40; e++) begin
                n_checks++;
                if (obs[d][e] !== exp_v[d][e])
                    $display("FAIL pend dut%0d cycle %0d: got %b expected %b", d + 1, e, obs[d][e], exp_v[d][e]);
                else n_pass++;
            end
    endtask

    task automatic test_reset_mid();
        int s_seen;
        clear_waves();
        reset_dut();
        s_seen = 0;
        for (int e = 0; e < 16; e++) begin
            set_req = (e >= 10);
            @(posedge clk);
            #1;
            if (s1 === 1'b1) s_seen++;
            if (e < 15) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (s_seen != 0 || {s1, busy1} !== 2'b00)
            $display("FAIL reset_mid_pre: early S=%0d S,busy=%b expected 0 and 00", s_seen, {s1, busy1});
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 13; r++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (s1 !== (r == 6))
                $display("FAIL reset_mid edge %0d: S=%b expected %b", r, s1, (r == 6));
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_hold_long();
        int s_cnt;
        clear_waves();
        for (int e = 10; e < 110; e++) ws[e] = 1'b1;
        for (int e = 120; e < 150; e++) ws[e] = 1'b1;
        run_waves(150);
        model(0, 150);
        model(1, 150);
        s_cnt = 0;
        for (int e = 0; e < 150; e++) if (obs[0][e][3] === 1'b1) s_cnt++;
        n_checks++;
        if (s_cnt != 2)
            $display("FAIL hold_count: S pulses=%0d expected 2", s_cnt);
        else n_pass++;
        for (int d = 0; d < 2; d++)
            for (int e = 0; e < 150; e++) begin
                n_checks++;
                if (obs[d][e] !== exp_v[d][e])
                    $display("FAIL hold dut%0d cycle %0d: got %b expected %b", d + 1, e, obs[d][e], exp_v[d][e]);
                else n_pass++;
            end
    endtask

    task automatic test_random();
        int len, pos;
        bit lvl;
        for (int run = 0; run < 4; run++) begin
            clear_waves();
            pos = 5;
            while (pos < 150) begin
                len = $urandom_range(1, 9);
                lvl = 1'($urandom_range(0, 1));
                for (int i = pos; i < pos + len && i < 150; i++) ws[i] = lvl;
                pos += len;
            end
            pos = 5;
            while (pos < 150) begin
                len = $urandom_range(1, 9);
                lvl = 1'($urandom_range(0, 1));
                for (int i = pos; i < pos + len && i < 150; i++) wc[i] = lvl;
                pos += len;
            end
            run_waves(150);
            model(0, 150);
            model(1, 150);
            for (int d = 0; d < 2; d++)
                for (int e = 0; e < 150; e++) begin
                    n_checks++;
                    if (obs[d][e] !== exp_v[d][e] || (obs[d][e][3] & obs[d][e][2]) !== 1'b0)
                        $display("FAIL random%0d dut%0d cycle %0d: got %b expected %b", run, d + 1, e, obs[d][e], exp_v[d][e]);
                    else n_pass++;
                end
        end
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_glitch();
        test_simultaneous();
        test_lock_pending();
        test_reset_mid();
        test_hold_long();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
